// File: rtl/ball_collision_ctrl.sv
// rtl/ball_collision_ctrl.sv - per-frame ball step requester and collision checker
//
// Purpose
//   Once per frame, requests ball sub-steps until the ball reports the end of the
//   frame. Each acknowledged step is captured, checked against the bottom edge,
//   the platform and the walls, and at most one collision cue is returned.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   i_game_start             abort the frame, return to idle, restore directions
//   i_cal_frame              start frame computation (honoured in idle only)
//   o_ball_req               step request, held until ack / frame end / abort
//   i_ball_ack               ball data valid for this step
//   i_ball_frame_term        ball finished all steps for this frame
//   i_ballX, i_ballY         ball top-left corner
//   i_ball_size              ball edge length
//   i_ball_speedX/Y          per-step delta sign: 00 = 0, 01 = +1, 11 = -1
//   i_platX, i_platY         platform top-left corner
//   o_ball_collision         one-cycle collision cue
//   o_direc_var              1..16 platform zone, 18 flip X, 19 flip Y, 0 none
//   o_life_lost              one-cycle pulse, ball reached the bottom edge
//   o_frame_done             one-cycle pulse, frame finished or aborted by life lost
module ball_collision_ctrl #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int WALL_L   = 0,
   parameter int WALL_T   = 0,
   parameter int PLAT_W   = 64,
   parameter int PLAT_H   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_game_start,
   input  logic       i_cal_frame,
   output logic       o_ball_req,
   input  logic       i_ball_ack,
   input  logic       i_ball_frame_term,
   input  logic [9:0] i_ballX,
   input  logic [8:0] i_ballY,
   input  logic [3:0] i_ball_size,
   input  logic [1:0] i_ball_speedX,
   input  logic [1:0] i_ball_speedY,
   input  logic [9:0] i_platX,
   input  logic [8:0] i_platY,
   output logic       o_ball_collision,
   output logic [5:0] o_direc_var,
   output logic       o_life_lost,
   output logic       o_frame_done
);

   localparam int          ZONE_SHIFT = $clog2(PLAT_W) - 4;
   localparam logic [10:0] H_LIM   = 11'(SCREEN_H - 1);
   localparam logic [10:0] W_LIM   = 11'(SCREEN_W - 1);
   localparam logic [10:0] WL      = 11'(WALL_L);
   localparam logic [10:0] WT      = 11'(WALL_T);
   localparam logic [10:0] PW      = 11'(PLAT_W);
   localparam logic [10:0] PH      = 11'(PLAT_H);
   localparam logic [10:0] OFF_MAX = 11'(PLAT_W - 1);

   localparam logic [5:0] CUE_FLIP_X = 6'd18;
   localparam logic [5:0] CUE_FLIP_Y = 6'd19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EVAL = 2'd2,
      FLAG = 2'd3
   } state_t;

   state_t     state;
   logic       dir_x_neg;   // 1: ball moving left
   logic       dir_y_neg;   // 1: ball moving up
   logic [9:0] cap_x;
   logic [8:0] cap_y;
   logic [3:0] cap_size;
   logic [9:0] cap_platx;
   logic [8:0] cap_platy;

   // All checks run on captured values in 11-bit unsigned arithmetic.
   logic [10:0] bx, by, bs, px, py;
   logic [10:0] bx_end, by_end, center, off;
   logic [5:0]  zone;
   logic        hit_bottom, hit_plat, hit_side, hit_top;

   assign bx     = {1'b0, cap_x};
   assign by     = {2'b0, cap_y};
   assign bs     = {7'b0, cap_size};
   assign px     = {1'b0, cap_platx};
   assign py     = {2'b0, cap_platy};
   assign bx_end = bx + bs;
   assign by_end = by + bs;
   assign center = bx + {8'b0, cap_size[3:1]};

   // Ball centre offset along the platform, clamped to the platform span.
   always_comb begin
      off = '0;
      if (center < px)
         off = '0;
      else if ((center - px) > OFF_MAX)
         off = OFF_MAX;
      else
         off = center - px;
   end

   assign zone = 6'(off >> ZONE_SHIFT) + 6'd1;

   assign hit_bottom = (by_end >= H_LIM);
   // Direction guards keep a ball still overlapping a surface from re-triggering.
   assign hit_plat   = !dir_y_neg && (by_end >= py) && (by <= py + PH) &&
                       (bx_end >= px) && (bx <= px + PW);
   assign hit_side   = ((bx <= WL) && dir_x_neg) || ((bx_end >= W_LIM) && !dir_x_neg);
   assign hit_top    = (by <= WT) && dir_y_neg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         o_ball_req       <= 1'b0;
         o_ball_collision <= 1'b0;
         o_direc_var      <= '0;
         o_life_lost      <= 1'b0;
         o_frame_done     <= 1'b0;
         dir_x_neg        <= 1'b0;
         dir_y_neg        <= 1'b0;
         cap_x            <= '0;
         cap_y            <= '0;
         cap_size         <= '0;
         cap_platx        <= '0;
         cap_platy        <= '0;
      end else begin
         // Cue and status outputs are single-cycle pulses.
         o_ball_collision <= 1'b0;
         o_direc_var      <= '0;
         o_life_lost      <= 1'b0;
         o_frame_done     <= 1'b0;

         if (i_game_start) begin
            state      <= IDLE;
            o_ball_req <= 1'b0;
            dir_x_neg  <= 1'b0;
            dir_y_neg  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (i_cal_frame) begin
                     state      <= REQ;
                     o_ball_req <= 1'b1;
                  end
               end

               REQ: begin
                  // Ack wins over a simultaneous frame_term; term is seen next REQ.
                  if (i_ball_ack) begin
                     cap_x      <= i_ballX;
                     cap_y      <= i_ballY;
                     cap_size   <= i_ball_size;
                     cap_platx  <= i_platX;
                     cap_platy  <= i_platY;
                     if (i_ball_speedX == 2'b01) dir_x_neg <= 1'b0;
                     if (i_ball_speedX == 2'b11) dir_x_neg <= 1'b1;
                     if (i_ball_speedY == 2'b01) dir_y_neg <= 1'b0;
                     if (i_ball_speedY == 2'b11) dir_y_neg <= 1'b1;
                     o_ball_req <= 1'b0;
                     state      <= EVAL;
                  end else if (i_ball_frame_term) begin
                     o_ball_req   <= 1'b0;
                     o_frame_done <= 1'b1;
                     state        <= IDLE;
                  end
               end

               EVAL: begin
                  state <= FLAG;
                  if (hit_bottom) begin
                     o_life_lost  <= 1'b1;
                     o_frame_done <= 1'b1;
                     state        <= IDLE;
                  end else if (hit_plat) begin
                     o_ball_collision <= 1'b1;
                     o_direc_var      <= zone;
                     dir_y_neg        <= 1'b1;
                     dir_x_neg        <= (zone <= 6'd8);
                  end else if (hit_side) begin
                     o_ball_collision <= 1'b1;
                     o_direc_var      <= CUE_FLIP_X;
                     dir_x_neg        <= !dir_x_neg;
                  end else if (hit_top) begin
                     o_ball_collision <= 1'b1;
                     o_direc_var      <= CUE_FLIP_Y;
                     dir_y_neg        <= !dir_y_neg;
                  end
               end

               FLAG: begin
                  state      <= REQ;
                  o_ball_req <= 1'b1;
               end

               default: begin
                  state      <= IDLE;
                  o_ball_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_collision_ctrl.sv
// tb/tb_ball_collision_ctrl.sv - scoreboard bench for ball_collision_ctrl
module tb_ball_collision_ctrl;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int PLAT_W   = 64;
   localparam int PLAT_H   = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_game_start;
   logic       i_cal_frame;
   logic       o_ball_req;
   logic       i_ball_ack;
   logic       i_ball_frame_term;
   logic [9:0] i_ballX;
   logic [8:0] i_ballY;
   logic [3:0] i_ball_size;
   logic [1:0] i_ball_speedX;
   logic [1:0] i_ball_speedY;
   logic [9:0] i_platX;
   logic [8:0] i_platY;
   logic       o_ball_collision;
   logic [5:0] o_direc_var;
   logic       o_life_lost;
   logic       o_frame_done;

   ball_collision_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_game_start     (i_game_start),
      .i_cal_frame      (i_cal_frame),
      .o_ball_req       (o_ball_req),
      .i_ball_ack       (i_ball_ack),
      .i_ball_frame_term(i_ball_frame_term),
      .i_ballX          (i_ballX),
      .i_ballY          (i_ballY),
      .i_ball_size      (i_ball_size),
      .i_ball_speedX    (i_ball_speedX),
      .i_ball_speedY    (i_ball_speedY),
      .i_platX          (i_platX),
      .i_platY          (i_platY),
      .o_ball_collision (o_ball_collision),
      .o_direc_var      (o_direc_var),
      .o_life_lost      (o_life_lost),
      .o_frame_done     (o_frame_done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [8:0]  exp_q[$];      // {collision, life_lost, frame_done, direc_var}
   int          mdx = 1;       // reference ball direction, +1 / -1
   int          mdy = 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every presented event is popped against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (o_ball_collision || o_life_lost || o_frame_done)) begin
         if (exp_q.size() == 0)
            check("unexpected_event", int'({o_ball_collision, o_life_lost, o_frame_done, o_direc_var}), 0);
         else
            check("event", int'({o_ball_collision, o_life_lost, o_frame_done, o_direc_var}),
                  int'(exp_q.pop_front()));
      end
   end

   // Reference model: the game rules on whole integers.
   task automatic model(input int x, input int y, input int sz, input int sx, input int sy,
                        input int px, input int py, output bit ended);
      int c;
      int zone;
      ended = 1'b0;
      if (sx == 1) mdx = 1;
      if (sx == 3) mdx = -1;
      if (sy == 1) mdy = 1;
      if (sy == 3) mdy = -1;
      if (y + sz >= SCREEN_H - 1) begin
         exp_q.push_back(9'b011_000000);
         ended = 1'b1;
      end else if (mdy == 1 && y + sz >= py && y <= py + PLAT_H &&
                   x + sz >= px && x <= px + PLAT_W) begin
         c = x + sz / 2 - px;
         if (c < 0) c = 0;
         if (c > PLAT_W - 1) c = PLAT_W - 1;
         zone = c * 16 / PLAT_W + 1;
         exp_q.push_back({3'b100, 6'(zone)});
         mdy = -1;
         mdx = (zone <= 8) ? -1 : 1;
      end else if ((x <= 0 && mdx == -1) || (x + sz >= SCREEN_W - 1 && mdx == 1)) begin
         exp_q.push_back({3'b100, 6'd18});
         mdx = -mdx;
      end else if (y <= 0 && mdy == -1) begin
         exp_q.push_back({3'b100, 6'd19});
         mdy = -mdy;
      end
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      @(negedge clk);
      while (!o_ball_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("req_seen", int'(o_ball_req), 1);
   endtask

   task automatic start_frame();
      @(negedge clk);
      i_cal_frame = 1'b1;
      @(posedge clk);
      #1 i_cal_frame = 1'b0;
   endtask

   task automatic do_step(input int x, input int y, input int sz, input int sx, input int sy,
                          input int px, input int py, input bit both, output bit ended);
      int hi;
      int lat;
      wait_req();
      i_ballX           = 10'(x);
      i_ballY           = 9'(y);
      i_ball_size       = 4'(sz);
      i_ball_speedX     = 2'(sx);
      i_ball_speedY     = 2'(sy);
      i_platX           = 10'(px);
      i_platY           = 9'(py);
      i_ball_ack        = 1'b1;
      i_ball_frame_term = both;
      i_cal_frame       = ($urandom_range(3, 0) == 0);
      model(x, y, sz, sx, sy, px, py, ended);
      @(posedge clk);
      #1;
      i_ball_ack        = 1'b0;
      i_ball_frame_term = 1'b0;
      i_cal_frame       = 1'b0;
      if (ended) begin
         hi = 0;
         repeat (4) begin
            @(negedge clk);
            if (o_ball_req) hi = 1;
         end
         check("req_after_life", hi, 0);
      end else begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!o_ball_req && lat < 10);
         check("step_latency", lat, 3);
      end
   endtask

   task automatic do_term();
      wait_req();
      i_ball_frame_term = 1'b1;
      exp_q.push_back(9'b001_000000);
      @(posedge clk);
      #1 i_ball_frame_term = 1'b0;
      @(negedge clk);
      check("req_after_term", int'(o_ball_req), 0);
   endtask

   function automatic int rand_speed();
      int r;
      r = $urandom_range(2, 0);
      return (r == 0) ? 0 : (r == 1) ? 1 : 3;
   endfunction

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ended;
      int x, y, sz, px, py, mode, nsteps;

      rst_n = 1'b0;
      i_game_start = 1'b0;
      i_cal_frame = 1'b0;
      i_ball_ack = 1'b0;
      i_ball_frame_term = 1'b0;
      i_ballX = '0;
      i_ballY = '0;
      i_ball_size = '0;
      i_ball_speedX = '0;
      i_ball_speedY = '0;
      i_platX = '0;
      i_platY = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            int'({o_ball_req, o_ball_collision, o_direc_var, o_life_lost, o_frame_done}), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Free flight, last ack coincident with frame_term.
      start_frame();
      do_step(320, 200, 8, 1, 1, 200, 440, 1'b0, ended);
      do_step(321, 201, 8, 1, 1, 200, 440, 1'b0, ended);
      do_step(322, 202, 8, 1, 1, 200, 440, 1'b1, ended);
      do_term();

      // Right wall, then no second cue while still touching it.
      start_frame();
      do_step(631, 200, 8, 1, 0, 200, 440, 1'b0, ended);
      do_step(631, 200, 8, 0, 0, 200, 440, 1'b0, ended);
      do_term();

      // Top-left corner: side first, then top.
      start_frame();
      do_step(0, 0, 8, 3, 3, 300, 440, 1'b0, ended);
      do_step(0, 0, 8, 0, 0, 300, 440, 1'b0, ended);
      do_term();

      // Platform centre zone and left clamp.
      start_frame();
      do_step(228, 433, 8, 0, 1, 200, 440, 1'b0, ended);
      do_step(190, 433, 12, 0, 1, 200, 440, 1'b0, ended);
      do_term();

      // Bottom edge.
      start_frame();
      do_step(100, 472, 8, 1, 1, 300, 440, 1'b0, ended);

      // Abort by game_start restores directions.
      start_frame();
      do_step(300, 200, 8, 3, 3, 200, 440, 1'b0, ended);
      wait_req();
      i_game_start = 1'b1;
      @(posedge clk);
      #1 i_game_start = 1'b0;
      mdx = 1;
      mdy = 1;
      @(negedge clk);
      check("req_after_abort", int'(o_ball_req), 0);
      start_frame();
      do_step(0, 0, 8, 0, 0, 300, 440, 1'b0, ended);
      do_term();

      // Asynchronous reset mid-frame.
      start_frame();
      do_step(300, 200, 8, 3, 3, 200, 440, 1'b0, ended);
      wait_req();
      rst_n = 1'b0;
      #1;
      check("async_reset_req", int'(o_ball_req), 0);
      mdx = 1;
      mdy = 1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      start_frame();
      do_step(0, 0, 8, 0, 0, 300, 440, 1'b0, ended);
      do_term();

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         start_frame();
         nsteps = $urandom_range(6, 1);
         ended = 1'b0;
         for (int s = 0; s < nsteps && !ended; s++) begin
            sz   = $urandom_range(15, 1);
            px   = $urandom_range(570, 0);
            py   = $urandom_range(460, 300);
            mode = $urandom_range(3, 0);
            case (mode)
               0: begin
                  x = $urandom_range(600, 20);
                  y = $urandom_range(420, 20);
               end
               1: begin
                  x = ($urandom_range(1, 0) == 1) ? 0 : SCREEN_W - 1 - sz + $urandom_range(1, 0);
                  y = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(300, 1);
               end
               2: begin
                  px = $urandom_range(560, 40);
                  x  = px + $urandom_range(70, 0) - sz;
                  y  = py - sz + $urandom_range(10, 0);
               end
               default: begin
                  x = $urandom_range(600, 20);
                  y = $urandom_range(475, 455);
               end
            endcase
            do_step(x, y, sz, rand_speed(), rand_speed(), px, py,
                    ($urandom_range(7, 0) == 0), ended);
         end
         if (!ended) do_term();
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
